alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_result_buffer_if.sv | 25 ++
 rtl/result_fifo.sv | 56 +++++
 rtl/alu_result_buffer.sv | 62 ++++++
 tb/tb_alu_result_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: mux select codes and the default result width.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_PLUS  = 2'd1,
        OP_MINUS = 2'd2,
        OP_MULT  = 2'd3
    } alu_op_e;

    localparam int ALU_DW = 8;
    localparam int OP_W   = 2;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer handshake bundle around the ALU result buffer.
interface alu_result_buffer_if
    import alu_pkg::*;
#(
    parameter int DW = ALU_DW
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [OP_W-1:0] in_op;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [OP_W-1:0] out_op;

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op
    );

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op
    );
endinterface

// File: rtl/result_fifo.sv
// Registered FIFO of DEPTH entries; no fall-through, read data zeroed when empty.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int EW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [EW-1:0]            wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [EW-1:0]            rd_data,
    input  logic                     rd_req,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Flow control depends only on registered occupancy.
    assign wr_ready = (count != CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign push     = wr_req & wr_ready;
    assign pop      = rd_valid & rd_req;

    // Empty (including reset) shows zero so stale storage never leaks out.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU mux results with their select codes and keeps a running sum.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ALU_DW,
    parameter int AW    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_result_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [AW-1:0]          acc,
    output logic                   acc_ovf,
    input  logic                   acc_clr
);
    localparam int EW = DW + OP_W;

    logic [EW-1:0] rd_entry;
    logic          push;
    logic [AW-1:0] acc_base;
    logic [AW:0]   acc_sum;

    result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (bus.in_valid),
        .wr_data  ({bus.in_data, bus.in_op}),
        .wr_ready (bus.in_ready),
        .rd_valid (bus.out_valid),
        .rd_data  (rd_entry),
        .rd_req   (bus.out_ready),
        .count    (count)
    );

    assign bus.out_data = rd_entry[EW-1:OP_W];
    assign bus.out_op   = rd_entry[OP_W-1:0];

    assign push = bus.in_valid & bus.in_ready;

    // A clear in the same cycle as a push zeroes the base before adding.
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_sum  = {1'b0, acc_base} + (AW+1)'(bus.in_data);

    // Running sum of accepted results with a sticky wrap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (push) begin
            acc     <= acc_sum[AW-1:0];
            acc_ovf <= (acc_ovf & ~acc_clr) | acc_sum[AW];
        end else if (acc_clr) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: queue model plus directed and random traffic.
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          acc_clr = 1'b0;
    logic [2:0]    count;
    logic [AW-1:0] acc;
    logic          acc_ovf;

    alu_result_buffer_if #(.DW(DW)) bus();

    alu_result_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .count   (count),
        .acc     (acc),
        .acc_ovf (acc_ovf),
        .acc_clr (acc_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];
    int         acc_m = 0;
    bit         ovf_m = 1'b0;
    int         sb_n;
    int         sb_s;
    logic [9:0] sb_e;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare visible state, pop on consumer handshake, then record accepted pushes.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_m = 0;
            ovf_m = 1'b0;
            chk("rst_count", int'(count), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_out_data", int'(bus.out_data), 0);
        end else begin
            sb_n = exp_q.size();
            chk("count", int'(count), sb_n);
            chk("in_ready", int'(bus.in_ready), int'(sb_n != DEPTH));
            chk("out_valid", int'(bus.out_valid), int'(sb_n != 0));
            chk("acc", int'(acc), acc_m);
            chk("acc_ovf", int'(acc_ovf), int'(ovf_m));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: got data 0x%0h expected no entry", bus.out_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), int'(sb_e[9:2]));
                    chk("out_op", int'(bus.out_op), int'(sb_e[1:0]));
                end
            end
            if (bus.in_valid && sb_n < DEPTH) begin
                exp_q.push_back({bus.in_data, bus.in_op});
                sb_s  = (acc_clr ? 0 : acc_m) + int'(bus.in_data);
                ovf_m = (acc_clr ? 1'b0 : ovf_m) | (sb_s >= (1 << AW));
                acc_m = sb_s % (1 << AW);
            end else if (acc_clr) begin
                acc_m = 0;
                ovf_m = 1'b0;
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input logic [1:0] op,
                       input bit rdy, input bit clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.out_ready = rdy;
        acc_clr       = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("init_count", int'(count), 0);
        chk("init_in_ready", int'(bus.in_ready), 1);
        chk("init_out_valid", int'(bus.out_valid), 0);
        chk("init_acc", int'(acc), 0);
        chk("init_ovf", int'(acc_ovf), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single push, visible one cycle later
        cyc(1'b1, 8'h05, 2'd1, 1'b0, 1'b0);
        chk("lat_out_valid", int'(bus.out_valid), 1);
        chk("lat_out_data", int'(bus.out_data), 'h05);
        chk("lat_out_op", int'(bus.out_op), 1);
        chk("lat_count", int'(count), 1);
        chk("lat_acc", int'(acc), 'h005);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h11 * (i + 1)), 2'(i), 1'b0, 1'b0);
        end
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(bus.in_ready), 0);
        cyc(1'b1, 8'h55, 2'd0, 1'b0, 1'b0);
        chk("drop_count", int'(count), 4);
        cyc(1'b1, 8'h66, 2'd2, 1'b1, 1'b0);
        chk("full_pop_count", int'(count), 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
        chk("drain_count", int'(count), 0);

        // Steady push+pop at count 2 across pointer wrap
        cyc(1'b1, 8'hA0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 2'd1, 1'b0, 1'b0);
        chk("hold2_count", int'(count), 2);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'(8'hB0 + i), 2'(i), 1'b1, 1'b0);
            chk("pp_count", int'(count), 2);
        end
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

        // Accumulator wrap and clear-with-push
        cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        chk("clr_acc", int'(acc), 0);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 8'hFF, 2'd3, 1'b1, 1'b0);
            if (i == 15) chk("ovf_before", int'(acc_ovf), 0);
        end
        chk("acc17", int'(acc), 'h0EF);
        chk("ovf17", int'(acc_ovf), 1);
        cyc(1'b1, 8'h01, 2'd1, 1'b1, 1'b0);
        chk("ovf_sticky", int'(acc_ovf), 1);
        cyc(1'b1, 8'h03, 2'd0, 1'b1, 1'b1);
        chk("clr_push_acc", int'(acc), 'h003);
        chk("clr_push_ovf", int'(acc_ovf), 0);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset with entries in flight
        cyc(1'b1, 8'hC1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 2'd3, 1'b0, 1'b0);
        #2 reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_out_data", int'(bus.out_data), 0);
        chk("arst_acc", int'(acc), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 8'h5A, 2'd2, 1'b0, 1'b0);
        chk("post_rst_data", int'(bus.out_data), 'h5A);
        cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

        // Pop requests on an empty buffer
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
            chk("empty_count", int'(count), 0);
            chk("empty_out_valid", int'(bus.out_valid), 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
        chk("final_count", int'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
